// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder front-end.
// Fires a periodic trigger pulse, times the synchronised echo pulse and
// converts its width to whole centimetres by counting a cycles-per-cm
// prescaler, so no divider is needed. The result is held on `distance`
// and announced with a one-cycle strobe. Missing or over-long echoes
// report the all-ones "no wall" distance together with `timeout`.
module ultrasonic_ranger #(
  parameter int CLK_FREQ_HZ    = 125000000,
  parameter int DIST_WIDTH     = 9,
  parameter int TRIG_CYCLES    = 1250,
  parameter int CYCLES_PER_CM  = 7250,
  parameter int TIMEOUT_CYCLES = 3750000,
  parameter int PERIOD_CYCLES  = 7500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  echo_in,
  output logic                  trig_out,
  output logic [DIST_WIDTH-1:0] distance,
  output logic                  distance_valid,
  output logic                  timeout,
  output logic                  busy
);

  localparam int TRIG_W   = (TRIG_CYCLES    > 1) ? $clog2(TRIG_CYCLES)    : 1;
  localparam int PRE_W    = (CYCLES_PER_CM  > 1) ? $clog2(CYCLES_PER_CM)  : 1;
  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PERIOD_W = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;

  localparam logic [TRIG_W-1:0]   TRIG_LAST   = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(CYCLES_PER_CM - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYCLES - 1);
  localparam logic [DIST_WIDTH-1:0] DIST_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t                state;
  logic                  echo_m;
  logic                  echo_s;
  logic                  echo_d;
  logic                  echo_rise;
  logic                  echo_fall;
  logic [TRIG_W-1:0]     trig_cnt;
  logic [PRE_W-1:0]      pre_cnt;
  logic [DIST_WIDTH-1:0] cm_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [PERIOD_W-1:0]   period_cnt;

  // Two-flop synchroniser for the raw echo, plus a delayed copy for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  // Measurement sequencer: trigger, wait for echo, time it, hold off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      trig_out       <= 1'b0;
      distance       <= '0;
      distance_valid <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
      trig_cnt       <= '0;
      pre_cnt        <= '0;
      cm_cnt         <= '0;
      to_cnt         <= '0;
      period_cnt     <= '0;
    end else begin
      distance_valid <= 1'b0;
      timeout        <= 1'b0;

      // The launch cycle in IDLE is cycle 0 of the period, so the next
      // trigger rises exactly PERIOD_CYCLES after this one.
      if (state != IDLE && period_cnt != PERIOD_LAST) begin
        period_cnt <= period_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state      <= TRIG;
            trig_out   <= 1'b1;
            busy       <= 1'b1;
            trig_cnt   <= '0;
            period_cnt <= PERIOD_W'(1);
          end
        end

        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            state    <= WAIT_RISE;
            trig_out <= 1'b0;
            to_cnt   <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end

        WAIT_RISE: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            state          <= HOLDOFF;
            distance       <= DIST_MAX;
            distance_valid <= 1'b1;
            timeout        <= 1'b1;
          end else if (echo_rise) begin
            // The rising-edge cycle is itself the first high cycle.
            state <= MEASURE;
            if (CYCLES_PER_CM == 1) begin
              pre_cnt <= '0;
              cm_cnt  <= DIST_WIDTH'(1);
            end else begin
              pre_cnt <= PRE_W'(1);
              cm_cnt  <= '0;
            end
          end
        end

        MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          if (echo_fall) begin
            state          <= HOLDOFF;
            distance       <= cm_cnt;
            distance_valid <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state          <= HOLDOFF;
            distance       <= DIST_MAX;
            distance_valid <= 1'b1;
            timeout        <= 1'b1;
          end else if (echo_s) begin
            if (pre_cnt == PRE_LAST) begin
              pre_cnt <= '0;
              if (cm_cnt != DIST_MAX) begin
                cm_cnt <= cm_cnt + 1'b1;
              end
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end

        HOLDOFF: begin
          // A stuck-high echo keeps us here until it finally drops.
          if (period_cnt == PERIOD_LAST && !echo_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
